contador32_monitor: RTL and testbench
=====================================

// Module: contador32_monitor
// PURPOSE
//  Cycle-accurate checker for the 32-bit chained counter (8 x 4-bit nibble stages).
//  - Sees the same enable/mode/D the counter sees, and keeps its own reference model of the count.
//  - Compares that model against the counter's Q/rco/load every clock.
//  - Flags, counts and latches mismatches.
//  - Sits beside the counter in synthesis-level benches and on-chip self-test.
// PARAMETERS
//  WIDTH      32  counter width; must be a multiple of NIB
//  NIB        4   width of D and of each cascaded stage
//  ERR_CNT_W  8   width of the saturating mismatch counter
// PORTS
//  clk        in   1          single clock; all state changes on posedge
//  reset      in   1          synchronous, active-high
//  enable     in   1          same enable driven into the counter
//  mode       in   2          same mode driven into the counter
//  D          in   NIB        same load nibble driven into the counter
//  dut_Q      in   WIDTH      counter output Q
//  dut_rco    in   1          counter ripple-carry out
//  dut_load   in   1          counter load indicator
//  clr_err    in   1          pulse: clear errors, resync model to dut_Q
//  exp_Q      out  WIDTH      model count value
//  err_q      out  1          1-cycle pulse: Q mismatch
//  err_rco    out  1          1-cycle pulse: rco mismatch
//  err_load   out  1          1-cycle pulse: load mismatch
//  fail       out  1          sticky: any mismatch since reset/clr_err
//  err_count  out  ERR_CNT_W  saturating count of mismatching cycles
// BEHAVIOUR
//  Reset: exp_Q=0, exp_rco=0, exp_load=0, all err_*=0, fail=0, err_count=0, state=IDLE.
//  Model update per edge, only when enable=1 (enable=0 holds exp_Q, exp_rco=0, exp_load=0):
//  - mode 00: exp_Q+1.
//  - mode 01: exp_Q-1.
//  - mode 10: exp_Q+3.
//  - mode 11: exp_Q={WIDTH/NIB{D}} (D replicated into every stage), exp_load=1.
//  - exp_rco=1 for one cycle when the 00/01/10 update wraps modulo 2^WIDTH, else 0.
//  Arithmetic is modulo 2^WIDTH; no saturation.
//  Latency:
//  - inputs at edge n produce exp_* valid after edge n, compared with dut_* in that same cycle.
//  - err_* pulses are registered and assert at edge n+1.
//  FSM:
//  - IDLE: no compares, model still tracks. -> TRACK on the first cycle with enable=1.
//  - TRACK: compares each cycle. Any mismatch -> FAIL, fail=1.
//  - FAIL: keeps comparing and counting; fail stays 1. -> TRACK on clr_err.
//  Mismatch cycle: one or more of err_q/err_rco/err_load set; err_count increments by 1.
//  - err_count saturates at 2^ERR_CNT_W-1; no wrap.
//  clr_err (any state except IDLE):
//  - next edge: fail=0, err_count=0, err_*=0, exp_Q<=dut_Q, state TRACK.
//  - clr_err together with a mismatch: clr wins; that mismatch is not counted.
//  Reset mid-run overrides everything, including clr_err.
//  - Returns to IDLE with exp_Q=0, which matches the counter's own reset value.
//  Boundaries that must match exactly:
//  - up wrap: FFFFFFFF->00000000, rco=1.
//  - down wrap: 00000000->FFFFFFFF, rco=1.
//  - +3 wrap: FFFFFFFE->00000001, rco=1.
//  - load in consecutive cycles with different D.
//  - mode change on the same edge as enable rising.
// CONFIGURATION
//  CONTADOR_MON_SNAPSHOT_EN defined:
//  - adds outputs snap_exp[WIDTH], snap_dut[WIDTH], snap_cycle[32].
//  - on the first mismatch after reset/clr_err, they capture exp_Q, dut_Q and the cycles-since-reset count.
//  - they hold until reset/clr_err; all three are 0 on reset.
//  Undefined: these ports and their registers do not exist; all other behaviour is identical.
// TESTING
//  1 reset, enable=1, mode=00 for 20 cycles, DUT correct
//    -> exp_Q=20, fail=0, err_count=0.
//  2 mode=11, D=4'hA -> exp_Q=AAAAAAAA, exp_load=1 one cycle.
//    Then mode=00 from FFFFFFFF -> exp_Q=0, exp_rco=1 for exactly one cycle.
//  3 mode=01 from 00000000 -> FFFFFFFF with rco=1.
//    mode=10 from FFFFFFFE -> 00000001 with rco=1.
//  4 force dut_Q bit 4 wrong for 3 cycles
//    -> err_q pulses on 3 edges, each one cycle late; err_count=3, fail=1 sticky.
//  5 clr_err on the same cycle as a mismatch
//    -> err_count=0, fail=0, exp_Q=dut_Q; next correct cycle err_q=0.
//  6 300 forced mismatches -> err_count=255 (saturated).
//    Then reset mid-count -> IDLE, all outputs 0.
//    With CONTADOR_MON_SNAPSHOT_EN, snap_* capture the first mismatch only.

Source files
------------

// File: rtl/contador32_monitor_if.sv
// Signal bundle between the chained-counter stimulus side and contador32_monitor.
// Latency: none, plain wires.
// Backpressure: none; every signal is sampled or driven once per clock.
// Optional ports exist only when CONTADOR_MON_SNAPSHOT_EN is defined.
interface contador32_monitor_if #(
  parameter int WIDTH     = 32,
  parameter int NIB       = 4,
  parameter int ERR_CNT_W = 8
);
  // Stimulus shared with the counter, plus the counter's own outputs
  logic                 enable;
  logic [1:0]           mode;
  logic [NIB-1:0]       D;
  logic [WIDTH-1:0]     dut_Q;
  logic                 dut_rco;
  logic                 dut_load;
  logic                 clr_err;

  // Monitor results
  logic [WIDTH-1:0]     exp_Q;
  logic                 err_q;
  logic                 err_rco;
  logic                 err_load;
  logic                 fail;
  logic [ERR_CNT_W-1:0] err_count;

`ifdef CONTADOR_MON_SNAPSHOT_EN
  logic [WIDTH-1:0]     snap_exp;
  logic [WIDTH-1:0]     snap_dut;
  logic [31:0]          snap_cycle;
`endif

  // Stimulus/observer side: drives counter activity, reads the verdicts
  modport master (
    output enable, mode, D, dut_Q, dut_rco, dut_load, clr_err,
`ifdef CONTADOR_MON_SNAPSHOT_EN
    input  snap_exp, snap_dut, snap_cycle,
`endif
    input  exp_Q, err_q, err_rco, err_load, fail, err_count
  );

  // Monitor side
  modport slave (
    input  enable, mode, D, dut_Q, dut_rco, dut_load, clr_err,
`ifdef CONTADOR_MON_SNAPSHOT_EN
    output snap_exp, snap_dut, snap_cycle,
`endif
    output exp_Q, err_q, err_rco, err_load, fail, err_count
  );
endinterface

// File: rtl/contador32_monitor.sv
// Cycle-accurate checker for the 32-bit chained nibble counter (model + compare + error tally).
// Latency: model valid 1 edge after inputs; err_* pulses one edge after the compared cycle.
// Backpressure: none; observes every cycle. Option macro: CONTADOR_MON_SNAPSHOT_EN (first-mismatch snapshot).
module contador32_monitor #(
  parameter int WIDTH     = 32,
  parameter int NIB       = 4,
  parameter int ERR_CNT_W = 8
) (
  input logic                clk,
  input logic                reset,
  contador32_monitor_if.slave bus
);

  localparam int STAGES = WIDTH / NIB;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAIL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Reference model of the counter
  logic [WIDTH-1:0] exp_q;
  logic             exp_rco;
  logic             exp_load;
  logic [WIDTH-1:0] model_q_nxt;
  logic             model_rco_nxt;
  logic             model_load_nxt;
  logic [WIDTH:0]   sum_ext;

  // Compare results and error bookkeeping
  logic                 cmp_active;
  logic                 fail_flag;
  logic                 mis_q;
  logic                 mis_rco;
  logic                 mis_load;
  logic                 mismatch;
  logic                 clr_act;
  logic                 count_hit;
  logic                 err_q_r;
  logic                 err_rco_r;
  logic                 err_load_r;
  logic [ERR_CNT_W-1:0] err_cnt;

  // Next model value: one extra bit on the arithmetic paths catches carry/borrow out of the top stage
  always_comb begin
    sum_ext        = '0;
    model_q_nxt    = exp_q;
    model_rco_nxt  = 1'b0;
    model_load_nxt = 1'b0;
    if (bus.enable) begin
      unique case (bus.mode)
        2'b00: begin
          sum_ext       = {1'b0, exp_q} + (WIDTH+1)'(1);
          model_q_nxt   = sum_ext[WIDTH-1:0];
          model_rco_nxt = sum_ext[WIDTH];
        end
        2'b01: begin
          sum_ext       = {1'b0, exp_q} - (WIDTH+1)'(1);
          model_q_nxt   = sum_ext[WIDTH-1:0];
          model_rco_nxt = sum_ext[WIDTH];
        end
        2'b10: begin
          sum_ext       = {1'b0, exp_q} + (WIDTH+1)'(3);
          model_q_nxt   = sum_ext[WIDTH-1:0];
          model_rco_nxt = sum_ext[WIDTH];
        end
        default: begin
          model_q_nxt    = {STAGES{bus.D}};
          model_load_nxt = 1'b1;
        end
      endcase
    end
  end

  // Per-field compare of model against the counter in the current cycle
  always_comb begin
    mis_q     = cmp_active && (bus.dut_Q    != exp_q);
    mis_rco   = cmp_active && (bus.dut_rco  != exp_rco);
    mis_load  = cmp_active && (bus.dut_load != exp_load);
    mismatch  = mis_q || mis_rco || mis_load;
    clr_act   = bus.clr_err && (state != ST_IDLE);
    count_hit = mismatch && !clr_act;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: clr_err beats a simultaneous mismatch
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (bus.enable) state_nxt = ST_TRACK;
      ST_TRACK: if (bus.clr_err) state_nxt = ST_TRACK;
                else if (mismatch) state_nxt = ST_FAIL;
      ST_FAIL:  if (bus.clr_err) state_nxt = ST_TRACK;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: compares run outside IDLE, sticky fail is simply the FAIL state
  always_comb begin
    cmp_active = (state != ST_IDLE);
    fail_flag  = (state == ST_FAIL);
  end

  // Model registers: clr_err resyncs the model onto whatever the counter currently shows
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q    <= '0;
      exp_rco  <= 1'b0;
      exp_load <= 1'b0;
    end else if (clr_act) begin
      exp_q    <= bus.dut_Q;
      exp_rco  <= 1'b0;
      exp_load <= 1'b0;
    end else begin
      exp_q    <= model_q_nxt;
      exp_rco  <= model_rco_nxt;
      exp_load <= model_load_nxt;
    end
  end

  // Registered error pulses
  always_ff @(posedge clk) begin
    if (reset || clr_act) begin
      err_q_r    <= 1'b0;
      err_rco_r  <= 1'b0;
      err_load_r <= 1'b0;
    end else begin
      err_q_r    <= mis_q;
      err_rco_r  <= mis_rco;
      err_load_r <= mis_load;
    end
  end

  // Saturating count of mismatching cycles
  always_ff @(posedge clk) begin
    if (reset || clr_act)             err_cnt <= '0;
    else if (count_hit && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
  end

  assign bus.exp_Q     = exp_q;
  assign bus.err_q     = err_q_r;
  assign bus.err_rco   = err_rco_r;
  assign bus.err_load  = err_load_r;
  assign bus.fail      = fail_flag;
  assign bus.err_count = err_cnt;

`ifdef CONTADOR_MON_SNAPSHOT_EN
  logic [31:0]      cyc;
  logic             snap_taken;
  logic [WIDTH-1:0] snap_exp_r;
  logic [WIDTH-1:0] snap_dut_r;
  logic [31:0]      snap_cycle_r;

  // Free-running cycles-since-reset count used to timestamp the snapshot
  always_ff @(posedge clk) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 32'd1;
  end

  // Capture the first counted mismatch only; cleared by reset or clr_err
  always_ff @(posedge clk) begin
    if (reset || clr_act) begin
      snap_taken   <= 1'b0;
      snap_exp_r   <= '0;
      snap_dut_r   <= '0;
      snap_cycle_r <= '0;
    end else if (count_hit && !snap_taken) begin
      snap_taken   <= 1'b1;
      snap_exp_r   <= exp_q;
      snap_dut_r   <= bus.dut_Q;
      snap_cycle_r <= cyc;
    end
  end

  assign bus.snap_exp   = snap_exp_r;
  assign bus.snap_dut   = snap_dut_r;
  assign bus.snap_cycle = snap_cycle_r;
`endif

endmodule

// File: tb/tb_contador32_monitor.sv
// Bench for contador32_monitor: emulates the counter with fault injection and predicts every output.
// Directed scenarios first, then a randomized phase.
// Optional snapshot outputs are checked when CONTADOR_MON_SNAPSHOT_EN is defined.
module tb_contador32_monitor;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  contador32_monitor_if bus();

  contador32_monitor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Emulated counter (correct behaviour) plus fault masks on its outputs
  bit [31:0] c_q;
  bit        c_rco, c_load;
  bit [31:0] q_mask;
  bit        rco_flip, load_flip;

  assign bus.dut_Q    = c_q ^ q_mask;
  assign bus.dut_rco  = c_rco ^ rco_flip;
  assign bus.dut_load = c_load ^ load_flip;

  // Predicted monitor state
  bit [31:0] m_q;
  bit        m_rco, m_load;
  bit        armed;
  bit        p_fail, pe_q, pe_rco, pe_load;
  int        p_cnt;
  bit        p_snap_taken;
  bit [31:0] p_snap_exp, p_snap_dut, p_snap_cyc, p_cyc;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_chk++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, req, $time);
    end
  endtask

  // Counter behaviour from plain integer arithmetic modulo 2^32
  function automatic void adv(input bit [31:0] q, input bit [1:0] md, input bit [3:0] d,
                              output bit [31:0] nq, output bit rco, output bit ld);
    longint v;
    v = 0;
    v[31:0] = q;
    rco = 1'b0;
    ld  = 1'b0;
    case (md)
      2'd0: v = v + 1;
      2'd1: v = v - 1;
      2'd2: v = v + 3;
      default: ;
    endcase
    if (md == 2'd3) begin
      nq = {d, d, d, d, d, d, d, d};
      ld = 1'b1;
    end else begin
      rco = (v < 0) || (v > 64'sh0_FFFF_FFFF);
      nq  = v[31:0];
    end
  endfunction

  task automatic predict_edge();
    bit [31:0] dq;
    bit        drco, dld, eq, er, el;
    dq   = bus.dut_Q;
    drco = bus.dut_rco;
    dld  = bus.dut_load;
    if (reset) begin
      m_q = 0; m_rco = 0; m_load = 0; armed = 0;
      p_fail = 0; pe_q = 0; pe_rco = 0; pe_load = 0; p_cnt = 0;
      p_snap_taken = 0; p_snap_exp = 0; p_snap_dut = 0; p_snap_cyc = 0; p_cyc = 0;
      c_q = 0; c_rco = 0; c_load = 0;
    end else begin
      eq = armed && (dq != m_q);
      er = armed && (drco != m_rco);
      el = armed && (dld != m_load);
      if (bus.clr_err && armed) begin
        pe_q = 0; pe_rco = 0; pe_load = 0; p_fail = 0; p_cnt = 0;
        m_q = dq; m_rco = 0; m_load = 0;
        p_snap_taken = 0; p_snap_exp = 0; p_snap_dut = 0; p_snap_cyc = 0;
      end else begin
        pe_q = eq; pe_rco = er; pe_load = el;
        if (eq || er || el) begin
          p_fail = 1;
          if (p_cnt < 255) p_cnt++;
          if (!p_snap_taken) begin
            p_snap_taken = 1; p_snap_exp = m_q; p_snap_dut = dq; p_snap_cyc = p_cyc;
          end
        end
        if (bus.enable) adv(m_q, bus.mode, bus.D, m_q, m_rco, m_load);
        else begin m_rco = 0; m_load = 0; end
      end
      if (bus.enable) armed = 1;
      p_cyc++;
      if (bus.enable) adv(c_q, bus.mode, bus.D, c_q, c_rco, c_load);
      else begin c_rco = 0; c_load = 0; end
    end
  endtask

  // One clock: inputs are already set; update models after the edge, check on the falling edge
  task automatic step();
    @(posedge clk);
    #1;
    predict_edge();
    @(negedge clk);
    chk("exp_q", bus.exp_Q, m_q);
    chk("err_q", bus.err_q, pe_q);
    chk("err_rco", bus.err_rco, pe_rco);
    chk("err_load", bus.err_load, pe_load);
    chk("fail", bus.fail, p_fail);
    chk("err_count", bus.err_count, p_cnt);
`ifdef CONTADOR_MON_SNAPSHOT_EN
    chk("snap_exp", bus.snap_exp, p_snap_exp);
    chk("snap_dut", bus.snap_dut, p_snap_dut);
    chk("snap_cycle", bus.snap_cycle, p_snap_cyc);
`endif
  endtask

  task automatic drive(input bit en, input bit [1:0] md, input bit [3:0] d);
    bus.enable = en;
    bus.mode   = md;
    bus.D      = d;
  endtask

  initial begin
    reset = 1'b1;
    bus.clr_err = 1'b0;
    drive(1'b0, 2'd0, 4'h0);
    q_mask = 0; rco_flip = 0; load_flip = 0;
    c_q = 0; c_rco = 0; c_load = 0;
    step();
    step();
    reset = 1'b0;

    // 1: count up 20 cycles with a correct counter
    drive(1'b1, 2'd0, 4'h0);
    for (int i = 0; i < 20; i++) step();
    chk("t1_q20", bus.exp_Q, 64'd20);
    chk("t1_fail", bus.fail, 1'b0);
    chk("t1_cnt", bus.err_count, 0);

    // 2: load A, then load F and wrap up to zero
    drive(1'b1, 2'd3, 4'hA); step();
    chk("t2_load_a", bus.exp_Q, 64'hAAAAAAAA);
    drive(1'b1, 2'd3, 4'hF); step();
    drive(1'b1, 2'd0, 4'h0); step();
    chk("t2_up_wrap", bus.exp_Q, 64'h0);
    step();
    chk("t2_after_wrap", bus.exp_Q, 64'h1);

    // 3: down wrap and +3 wrap
    drive(1'b1, 2'd3, 4'h0); step();
    drive(1'b1, 2'd1, 4'h0); step();
    chk("t3_down_wrap", bus.exp_Q, 64'hFFFFFFFF);
    step();
    chk("t3_down", bus.exp_Q, 64'hFFFFFFFE);
    drive(1'b1, 2'd2, 4'h0); step();
    chk("t3_plus3_wrap", bus.exp_Q, 64'h1);

    // 4: bit 4 of Q wrong for three cycles
    drive(1'b1, 2'd0, 4'h0);
    q_mask = 32'h10;
    for (int i = 0; i < 3; i++) step();
    chk("t4_cnt", bus.err_count, 3);
    chk("t4_fail", bus.fail, 1'b1);
    q_mask = 0;
    step();
    chk("t4_err_q_clean", bus.err_q, 1'b0);
    chk("t4_fail_sticky", bus.fail, 1'b1);

    // 5: counter glitches and clr_err lands on the mismatching cycle
    c_q = c_q ^ 32'h10;
    drive(1'b0, 2'd0, 4'h0);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    chk("t5_cnt", bus.err_count, 0);
    chk("t5_fail", bus.fail, 1'b0);
    chk("t5_resync", bus.exp_Q, c_q);
    drive(1'b1, 2'd0, 4'h0);
    for (int i = 0; i < 3; i++) step();
    chk("t5_err_q", bus.err_q, 1'b0);

    // Consecutive loads with different D, then enable rising together with a mode change
    drive(1'b1, 2'd3, 4'h3); step();
    chk("ld_3", bus.exp_Q, 64'h33333333);
    drive(1'b1, 2'd3, 4'hC); step();
    chk("ld_c", bus.exp_Q, 64'hCCCCCCCC);
    drive(1'b0, 2'd0, 4'h0); step();
    drive(1'b1, 2'd2, 4'h0); step();
    chk("en_rise_plus3", bus.exp_Q, 64'hCCCCCCCF);

    // 6: 300 mismatching cycles saturate the counter, then reset beats clr_err
    q_mask = 32'h1;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'($urandom_range(0, 2)), 4'($urandom));
      step();
    end
    chk("t6_sat", bus.err_count, 255);
    q_mask = 0;
    reset = 1'b1;
    bus.clr_err = 1'b1;
    step();
    reset = 1'b0;
    bus.clr_err = 1'b0;
    chk("t6_rst_q", bus.exp_Q, 64'h0);
    chk("t6_rst_cnt", bus.err_count, 0);
    chk("t6_rst_fail", bus.fail, 1'b0);

    // Randomized phase with sparse faults, clears and resets
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom));
      q_mask      = ($urandom_range(0, 19) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      rco_flip    = ($urandom_range(0, 29) == 0);
      load_flip   = ($urandom_range(0, 29) == 0);
      bus.clr_err = ($urandom_range(0, 24) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
